// File: rtl/ecg_spike_event_packer.sv
// Packs ECG spike-neuron events into {pos, neg, delta} words and buffers them in a show-ahead FIFO.
// Optional per-window spike rate counters are built only when SPIKE_RATE_WIN_EN is defined.
module ecg_spike_event_packer #(
   parameter int DEPTH = 8,
   parameter int DT_W  = 14,
   parameter int WIN   = 360
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic            spike_pos,
   input  logic            spike_neg,
   output logic [DT_W+1:0] evt_data,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [7:0]      drop_cnt,
   output logic            ovf
`ifdef SPIKE_RATE_WIN_EN
   ,
   output logic [7:0]      rate_pos,
   output logic [7:0]      rate_neg,
   output logic [0:0]      rate_stb
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   // delta_q holds completed cycles; the word reports delta_q+1 so the current cycle is included.
   localparam logic [DT_W-1:0] DELTA_LAST = {{(DT_W-1){1'b1}}, 1'b0};

   generate
      if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || WIN < 2) begin : g_param_chk
         $error("ecg_spike_event_packer: illegal DEPTH or WIN");
      end
   endgenerate

   logic [DT_W+1:0] mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic [DT_W-1:0] delta_q, delta_inc;
   logic            evt_det, mark, push, pop, full, accept, drop;
   logic [DT_W+1:0] word;

   assign delta_inc = delta_q + DT_W'(1);
   assign evt_det   = en & (spike_pos | spike_neg);
   assign mark      = en & ~(spike_pos | spike_neg) & (delta_q == DELTA_LAST);
   assign push      = evt_det | mark;
   assign word      = evt_det ? {spike_pos, spike_neg, delta_inc} : {2'b00, {DT_W{1'b1}}};

   assign full      = (count_q == FULL_CNT);
   assign evt_valid = (count_q != '0);
   assign pop       = evt_valid & evt_ready;
   // A full FIFO still takes a word when the head leaves on the same edge.
   assign accept    = push & (~full | pop);
   assign drop      = push & full & ~pop;
   assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;

   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wr_ptr_q] <= word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         delta_q  <= '0;
         drop_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         if (en) begin
            delta_q <= push ? '0 : delta_inc;
         end
         if (accept) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (accept && !pop) begin
            count_q <= count_q + (AW+1)'(1);
         end else if (!accept && pop) begin
            count_q <= count_q - (AW+1)'(1);
         end
         if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

`ifdef SPIKE_RATE_WIN_EN
   localparam int WW = $clog2(WIN);

   logic [WW-1:0] win_q;
   logic [7:0]    pos_q, neg_q;

   function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic inc);
      return (inc && c != 8'hFF) ? c + 8'd1 : c;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_q    <= '0;
         pos_q    <= '0;
         neg_q    <= '0;
         rate_pos <= '0;
         rate_neg <= '0;
         rate_stb <= '0;
      end else begin
         rate_stb <= 1'b0;
         if (en) begin
            if (win_q == WW'(WIN - 1)) begin
               win_q    <= '0;
               pos_q    <= '0;
               neg_q    <= '0;
               rate_pos <= sat_inc(pos_q, spike_pos);
               rate_neg <= sat_inc(neg_q, spike_neg);
               rate_stb <= 1'b1;
            end else begin
               win_q <= win_q + WW'(1);
               pos_q <= sat_inc(pos_q, spike_pos);
               neg_q <= sat_inc(neg_q, spike_neg);
            end
         end
      end
   end
`endif

endmodule
